wb_burst_master: RTL

WB_BURST_MASTER -- requirements
Module: wb_burst_master

---
 rtl/wb_common_pkg.sv | 46 ++++
 rtl/wb_burst_adr_gen.sv | 59 +++++
 rtl/wb_burst_master.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/wb_common_pkg.sv
// ---------------------------------------------------------------------------
// wb_common_pkg
//
// Shared Wishbone B4 definitions for the burst master family:
//   - cycle type identifier (CTI) encodings
//   - burst type extension (BTE) encodings
//   - wb_next_adr(): address of the next beat of a burst, either a plain
//     linear increment or a wrap inside an aligned 4/8/16-beat block
//
// No ports; import with "import wb_common_pkg::*;".
// ---------------------------------------------------------------------------
package wb_common_pkg;

    // Cycle type identifiers placed on wb_cti_o
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // Burst type extensions placed on wb_bte_o
    localparam logic [1:0] BTE_LINEAR  = 2'd0;
    localparam logic [1:0] BTE_WRAP4   = 2'd1;
    localparam logic [1:0] BTE_WRAP8   = 2'd2;
    localparam logic [1:0] BTE_WRAP16  = 2'd3;

    // Next beat address. The address is carried at 64 bits so the one
    // function serves every address width; callers cast the result back.
    // blk_mask selects the bits that move within the wrap block: for a
    // linear burst every bit moves, for a wrapping burst only the offset
    // inside the (beats * step)-byte aligned block moves and the block
    // base is kept from the current address.
    function automatic logic [63:0] wb_next_adr(input logic [63:0] adr,
                                                input logic [1:0]  bte,
                                                input logic [63:0] step);
        logic [63:0] inc;
        logic [63:0] blk_mask;
        inc = adr + step;
        case (bte)
            BTE_WRAP4:  blk_mask = (step << 2) - 64'd1;
            BTE_WRAP8:  blk_mask = (step << 3) - 64'd1;
            BTE_WRAP16: blk_mask = (step << 4) - 64'd1;
            default:    blk_mask = '1;
        endcase
        return (adr & ~blk_mask) | (inc & blk_mask);
    endfunction

endpackage

// File: rtl/wb_burst_adr_gen.sv
// ---------------------------------------------------------------------------
// wb_burst_adr_gen
//
// Address and beat-count generator for a Wishbone burst. Loads the start
// address and beat count when a command is accepted, then on every
// completed beat steps the address by one bus word (linear or wrapping
// according to bte) and decrements the count of beats still to complete.
//
// Ports:
//   wb_clk_i    in   clock, rising edge
//   wb_rst_ni   in   asynchronous active-low reset
//   load        in   capture load_adr / load_len
//   load_adr    in   [aw] start byte address
//   load_len    in   [lw] beat count
//   bte         in   [2]  burst type used for the wrap
//   advance     in   a beat completed this cycle
//   adr         out  [aw] current beat address (registered)
//   beats_left  out  [lw] beats not yet completed, including current one
//   last_beat   out  current beat is the final one
// ---------------------------------------------------------------------------
module wb_burst_adr_gen
    import wb_common_pkg::*;
#(
    parameter int aw = 32,
    parameter int dw = 32,
    parameter int lw = 5
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    input  logic          load,
    input  logic [aw-1:0] load_adr,
    input  logic [lw-1:0] load_len,
    input  logic [1:0]    bte,
    input  logic          advance,
    output logic [aw-1:0] adr,
    output logic [lw-1:0] beats_left,
    output logic          last_beat
);

    localparam logic [63:0] STEP = 64'(dw / 8);

    // A load always wins over an advance; the two never coincide in the
    // master because a command is only loaded while no burst is running.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            adr        <= '0;
            beats_left <= '0;
        end else if (load) begin
            adr        <= load_adr;
            beats_left <= load_len;
        end else if (advance) begin
            adr        <= aw'(wb_next_adr(64'(adr), bte, STEP));
            beats_left <= beats_left - lw'(1);
        end
    end

    assign last_beat = (beats_left == lw'(1));

endmodule

// File: rtl/wb_burst_master.sv
// ---------------------------------------------------------------------------
// wb_burst_master
//
// Turns a single command (start address, direction, length, burst type)
// into a Wishbone B4 registered-feedback burst. Write data is taken from a
// valid/ready stream into a one-entry holding register that drives
// wb_dat_o; read data is returned as one-cycle pulses with no backpressure.
// A command ends with a one-cycle done_o pulse; err_o marks an abort caused
// by wb_err_i or wb_rty_i.
//
// Ports:
//   wb_clk_i, wb_rst_ni            clock / async active-low reset
//   cmd_valid_i, cmd_ready_o       command handshake
//   cmd_adr_i [aw]                 start byte address (word aligned)
//   cmd_we_i                       1 = write burst, 0 = read burst
//   cmd_len_i [clog2(MAX_LEN)+1]   beat count 1..MAX_LEN
//   cmd_bte_i [2]                  0 linear, 1 wrap4, 2 wrap8, 3 wrap16
//   wdat_valid_i, wdat_i, wdat_ready_o   write beat stream
//   rdat_valid_o, rdat_o           read beat pulses
//   done_o, err_o                  end-of-command pulse and status
//   wb_*                           Wishbone master interface
// ---------------------------------------------------------------------------
module wb_burst_master
    import wb_common_pkg::*;
#(
    parameter int dw      = 32,
    parameter int aw      = 32,
    parameter int MAX_LEN = 16
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_ni,

    input  logic                         cmd_valid_i,
    output logic                         cmd_ready_o,
    input  logic [aw-1:0]                cmd_adr_i,
    input  logic                         cmd_we_i,
    input  logic [$clog2(MAX_LEN):0]     cmd_len_i,
    input  logic [1:0]                   cmd_bte_i,

    input  logic                         wdat_valid_i,
    input  logic [dw-1:0]                wdat_i,
    output logic                         wdat_ready_o,

    output logic                         rdat_valid_o,
    output logic [dw-1:0]                rdat_o,

    output logic                         done_o,
    output logic                         err_o,

    output logic [aw-1:0]                wb_adr_o,
    output logic [dw-1:0]                wb_dat_o,
    output logic [dw/8-1:0]              wb_sel_o,
    output logic                         wb_we_o,
    output logic [2:0]                   wb_cti_o,
    output logic [1:0]                   wb_bte_o,
    output logic                         wb_cyc_o,
    output logic                         wb_stb_o,
    input  logic                         wb_ack_i,
    input  logic                         wb_err_i,
    input  logic                         wb_rty_i,
    input  logic [dw-1:0]                wb_dat_i
);

    localparam int LW = $clog2(MAX_LEN) + 1;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    logic [0:0]    state;
    logic [LW-1:0] load_left;
    logic [LW-1:0] beats_left;
    logic          last_beat;
    logic          accept;
    logic          beat_ack;
    logic          beat_abort;
    logic          final_ack;
    logic          wdat_take;

    // Handshake and bus-event decode. Responses only count while a strobe
    // is out; an error or retry takes priority over a simultaneous ack so
    // the beat is never treated as completed.
    assign cmd_ready_o = (state == IDLE);
    assign accept      = cmd_valid_i & cmd_ready_o;
    assign beat_ack    = wb_stb_o & wb_ack_i & ~wb_err_i & ~wb_rty_i;
    assign beat_abort  = wb_stb_o & (wb_err_i | wb_rty_i);
    assign final_ack   = beat_ack & last_beat;

    // The holding register may be refilled in the same cycle its current
    // beat is acked, which keeps a streaming write at one beat per cycle.
    assign wdat_ready_o = (state == ACTIVE) & wb_we_o & (load_left != '0)
                        & (~wb_stb_o | beat_ack);
    assign wdat_take    = wdat_valid_i & wdat_ready_o;

    // Address stepping and the count of beats still to complete.
    wb_burst_adr_gen #(
        .aw (aw),
        .dw (dw),
        .lw (LW)
    ) u_adr_gen (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_ni  (wb_rst_ni),
        .load       (accept),
        .load_adr   (cmd_adr_i),
        .load_len   (cmd_len_i),
        .bte        (wb_bte_o),
        .advance    (beat_ack),
        .adr        (wb_adr_o),
        .beats_left (beats_left),
        .last_beat  (last_beat)
    );

    // Main sequencer. All Wishbone outputs and the status pulses are
    // registered here. A read burst raises its strobe together with cyc and
    // holds it until the last ack; a write burst only strobes while the
    // holding register has data, so data starvation shows up as cyc high
    // with stb low and the CTI left untouched. The CTI switches to
    // end-of-burst when the second-to-last beat completes, so the final beat
    // is presented with it. Either the final ack or an abort ends the
    // command: the bus is released, done_o pulses and the master is ready
    // again in that same cycle.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state        <= IDLE;
            load_left    <= '0;
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            wb_we_o      <= 1'b0;
            wb_cti_o     <= CTI_CLASSIC;
            wb_bte_o     <= BTE_LINEAR;
            wb_sel_o     <= '0;
            wb_dat_o     <= '0;
            rdat_o       <= '0;
            rdat_valid_o <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            rdat_valid_o <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= ACTIVE;
                        wb_cyc_o  <= 1'b1;
                        wb_stb_o  <= ~cmd_we_i;
                        wb_we_o   <= cmd_we_i;
                        wb_bte_o  <= cmd_bte_i;
                        wb_sel_o  <= '1;
                        wb_cti_o  <= (cmd_len_i == LW'(1)) ? CTI_CLASSIC : CTI_INCR;
                        load_left <= cmd_we_i ? cmd_len_i : '0;
                    end
                end
                ACTIVE: begin
                    if (beat_abort || final_ack) begin
                        state    <= IDLE;
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_sel_o <= '0;
                        done_o   <= 1'b1;
                        err_o    <= beat_abort;
                    end else begin
                        if (beat_ack && beats_left == LW'(2)) begin
                            wb_cti_o <= CTI_EOB;
                        end
                        if (wb_we_o) begin
                            if (wdat_take) begin
                                wb_stb_o <= 1'b1;
                            end else if (beat_ack) begin
                                wb_stb_o <= 1'b0;
                            end
                        end
                    end
                    if (beat_ack && !wb_we_o) begin
                        rdat_o       <= wb_dat_i;
                        rdat_valid_o <= 1'b1;
                    end
                    if (wdat_take) begin
                        wb_dat_o  <= wdat_i;
                        load_left <= load_left - LW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
